// File: rtl/dec_pkg.sv
// Shared types for the decode control pipeline: control bundle, opcodes, FSM states.
// Used by dec_lane and decode_ctrl_pipe (optional counters: DECODE_PERF_EN).
package dec_pkg;

    localparam int CTRL_W  = 17;
    localparam int CSR_BIT = 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic       csr;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {
        IDLE,
        CSR_WAIT
    } dec_state_e;

endpackage

// File: rtl/dec_lane.sv
// Combinational opcode -> control bundle decoder for one lane.
// An invalid lane yields an all-zero bundle.
module dec_lane
    import dec_pkg::*;
(
    input  logic              vld,
    input  logic [6:0]        opcode,
    output logic [CTRL_W-1:0] ctrl
);

    logic [13:0] lead;
    logic        illegal;
    ctrl_t       c;

    always_comb begin
        lead    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD:   lead = 14'b10_0000_1001_0000;
            OP_STORE:  lead = 14'b00_0100_1100_0000;
            OP_OP:     lead = 14'b10_0000_0000_0100;
            OP_BRANCH: lead = 14'b00_1000_0000_1010;
            OP_IMM:    lead = 14'b10_0000_1000_0100;
            OP_JAL:    lead = 14'b10_1100_0010_0001;
            OP_JALR:   lead = 14'b10_0000_1010_0000;
            OP_LUI:    lead = 14'b11_0010_1000_0000;
            OP_AUIPC:  lead = 14'b11_0001_1000_0000;
            OP_SYSTEM: lead = 14'b11_0100_1000_0100;
            default:   illegal = 1'b1;
        endcase
        c    = ctrl_t'({lead, (opcode == OP_JALR), (opcode == OP_SYSTEM), illegal});
        ctrl = vld ? c : '0;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered multi-lane main-control decoder with output register + one skid entry,
// CSR serialisation FSM, and optional perf counters under DECODE_PERF_EN.
module decode_ctrl_pipe
    import dec_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_vld,
    input  logic [LANES*INSTR_W-1:0] in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_vld,
    output logic [LANES*INSTR_W-1:0] out_instr,
    output logic [LANES*CTRL_W-1:0]  out_ctrl,
    input  logic                     csr_done
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]              perf_groups,
    output logic [31:0]              perf_stalls
`endif
);

    localparam int GRP_W = LANES * (1 + INSTR_W + CTRL_W);

    // Handshake: a group moves on a port in any cycle where its valid and ready are both high.
    // in_ready depends only on registered state, never on in_valid.
    logic [LANES*CTRL_W-1:0] dec_ctrl;
    logic [GRP_W-1:0]        in_grp;
    logic [GRP_W-1:0]        out_grp_q;
    logic [GRP_W-1:0]        skid_grp_q;
    logic                    out_valid_q;
    logic                    skid_full_q;
    logic                    accept;
    logic                    take;
    logic                    has_csr;
    dec_state_e              state;
    dec_state_e              state_next;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            dec_lane u_lane (
                .vld    (in_lane_vld[g]),
                .opcode (in_instr[g*INSTR_W +: 7]),
                .ctrl   (dec_ctrl[g*CTRL_W +: CTRL_W])
            );
        end
    endgenerate

    always_comb begin
        has_csr = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            has_csr = has_csr | dec_ctrl[i*CTRL_W + CSR_BIT];
        end
    end

    assign in_grp   = {in_lane_vld, in_instr, dec_ctrl};
    assign in_ready = rst_n && !skid_full_q && (state == IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign take     = out_valid_q && out_ready;

    assign out_valid    = out_valid_q;
    assign out_lane_vld = out_grp_q[GRP_W-1 -: LANES];
    assign out_instr    = out_grp_q[LANES*CTRL_W +: LANES*INSTR_W];
    assign out_ctrl     = out_grp_q[LANES*CTRL_W-1:0];

    // Skid holds a group only while the output register is occupied and stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            out_grp_q   <= '0;
            skid_grp_q  <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (!out_valid_q || take) begin
            if (skid_full_q) begin
                out_grp_q   <= skid_grp_q;
                out_valid_q <= 1'b1;
                skid_full_q <= 1'b0;
            end else if (accept) begin
                out_grp_q   <= in_grp;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_grp_q  <= in_grp;
            skid_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && has_csr) state_next = CSR_WAIT;
                CSR_WAIT: if (csr_done) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_groups <= '0;
            perf_stalls <= '0;
        end else begin
            if (take) begin
                perf_groups <= perf_groups + 32'd1;
            end
            if (out_valid_q && !out_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe with LANES=2; perf checks under DECODE_PERF_EN.
module tb_decode_ctrl_pipe;

    localparam int GRP_W = 100;

    localparam logic [31:0] I_LD    = 32'h00002083;
    localparam logic [31:0] I_ST    = 32'h00112023;
    localparam logic [31:0] I_ADD   = 32'h00208133;
    localparam logic [31:0] I_BR    = 32'h00208463;
    localparam logic [31:0] I_ADDI  = 32'h00A00093;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_CSRRW = 32'h30001073;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;

    localparam logic [16:0] C_LD    = 17'h10480;
    localparam logic [16:0] C_ST    = 17'h02600;
    localparam logic [16:0] C_R     = 17'h10020;
    localparam logic [16:0] C_BR    = 17'h04050;
    localparam logic [16:0] C_I     = 17'h10420;
    localparam logic [16:0] C_JAL   = 17'h16108;
    localparam logic [16:0] C_JALR  = 17'h10504;
    localparam logic [16:0] C_LUI   = 17'h19400;
    localparam logic [16:0] C_AUIPC = 17'h18C00;
    localparam logic [16:0] C_CSR   = 17'h1A422;
    localparam logic [16:0] C_ILL   = 17'h00001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_lane_vld = '0;
    logic [63:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_lane_vld;
    logic [63:0] out_instr;
    logic [33:0] out_ctrl;
    logic        csr_done = 1'b0;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_groups;
    logic [31:0] perf_stalls;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [GRP_W-1:0] exp_q[$];

    decode_ctrl_pipe #(.LANES(2), .INSTR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_vld  (in_lane_vld),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_vld (out_lane_vld),
        .out_instr    (out_instr),
        .out_ctrl     (out_ctrl),
        .csr_done     (csr_done)
`ifdef DECODE_PERF_EN
        ,
        .perf_groups  (perf_groups),
        .perf_stalls  (perf_stalls)
`endif
    );

    // clock/reset: posedges at 5,15,...; inputs change on negedges
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] vld, input logic [31:0] i1, input logic [31:0] i0,
                        input logic [16:0] c1, input logic [16:0] c0);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_lane_vld = vld;
        in_instr    = {i1, i0};
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back({vld, i1, i0, c1, c0});
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    // monitor: samples 1 time unit before each posedge
    logic [GRP_W-1:0] mon_prev;
    logic [GRP_W-1:0] mon_cur;
    logic [GRP_W-1:0] mon_exp;
    bit               mon_have_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            mon_cur = {out_lane_vld, out_instr, out_ctrl};
            if (!rst_n) begin
                mon_have_prev = 1'b0;
            end else begin
                if (mon_have_prev) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", mon_cur, mon_prev);
                end
                mon_have_prev = out_valid && !out_ready && !flush;
                mon_prev = mon_cur;
                if (out_valid && out_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_group: got %h expected none", mon_cur);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("group", mon_cur, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_lane_vld", out_lane_vld, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        // basic decode and 1-cycle latency
        out_ready = 1'b1;
        send(2'b11, I_ADD, I_ADDI, C_R, C_I);
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
        send(2'b11, I_ST, I_LD, C_ST, C_LD);
        send(2'b11, I_JAL, I_BR, C_JAL, C_BR);
        send(2'b11, I_LUI, I_JALR, C_LUI, C_JALR);
        send(2'b11, I_CSRRW, I_AUIPC, C_CSR, C_AUIPC);
        repeat (2) @(negedge clk);
        csr_done = 1'b1;
        @(negedge clk);
        csr_done = 1'b0;
        check("csr_lane1_release", in_ready, 1);
        send(2'b11, I_ILL, I_ADDI, C_ILL, C_I);
        send(2'b01, I_ADD, I_ADDI, 17'h0, C_I);
        send(2'b10, I_LD, I_ILL, C_LD, 17'h0);
        repeat (3) @(negedge clk);

        // back-pressure: two groups fit, third is held off
        out_ready = 1'b0;
        send(2'b11, I_ADD, I_ADDI, C_R, C_I);
        send(2'b11, I_ST, I_LD, C_ST, C_LD);
        @(negedge clk);
        in_valid    = 1'b1;
        in_lane_vld = 2'b11;
        in_instr    = {I_JAL, I_BR};
        check("bp_full_0", in_ready, 0);
        @(negedge clk);
        check("bp_full_1", in_ready, 0);
        @(negedge clk);
        check("bp_full_2", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(2'b11, I_JAL, I_BR, C_JAL, C_BR);
        repeat (4) @(negedge clk);
        check("bp_drained", exp_q.size(), 0);

        // CSR serialisation
        send(2'b11, I_ADDI, I_CSRRW, C_I, C_CSR);
        @(negedge clk);
        check("csr_block_0", in_ready, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("csr_block_n", in_ready, 0);
        end
        csr_done = 1'b1;
        @(negedge clk);
        csr_done = 1'b0;
        check("csr_release", in_ready, 1);
        send(2'b01, I_CSRRW, I_ADDI, 17'h0, C_I);
        @(negedge clk);
        check("csr_masked_lane", in_ready, 1);
        repeat (2) @(negedge clk);

        // flush with output and skid full
        out_ready = 1'b0;
        send(2'b11, I_ADD, I_ADDI, C_R, C_I);
        send(2'b11, I_ST, I_LD, C_ST, C_LD);
        @(negedge clk);
        check("flush_pre_full", in_ready, 0);
        flush       = 1'b1;
        in_valid    = 1'b1;
        in_lane_vld = 2'b11;
        in_instr    = {I_LUI, I_JALR};
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        // flush with empty pipe discards the offered group
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_discard", out_valid, 0);
        repeat (3) @(negedge clk);
        check("flush_nothing", out_valid, 0);

        // flush and csr_done together during CSR_WAIT
        send(2'b01, I_ADD, I_CSRRW, 17'h0, C_CSR);
        repeat (2) @(negedge clk);
        check("csr_wait_again", in_ready, 0);
        flush    = 1'b1;
        csr_done = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        csr_done = 1'b0;
        exp_q.delete();
        check("flush_csr_in_ready", in_ready, 1);

        // fresh reset, then counters and mid-burst reset
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        send(2'b11, I_ADD, I_ADDI, C_R, C_I);
        send(2'b11, I_ST, I_LD, C_ST, C_LD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        send(2'b11, I_JAL, I_BR, C_JAL, C_BR);
        send(2'b11, I_LUI, I_JALR, C_LUI, C_JALR);
        send(2'b01, I_ADD, I_AUIPC, 17'h0, C_AUIPC);
        repeat (2) @(negedge clk);
        check("burst_drained", exp_q.size(), 0);
`ifdef DECODE_PERF_EN
        check("perf_groups", perf_groups, 5);
        check("perf_stalls", perf_stalls, 4);
`endif
        out_ready = 1'b0;
        send(2'b11, I_ADD, I_ADDI, C_R, C_I);
        send(2'b11, I_ST, I_LD, C_ST, C_LD);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_ctrl", out_ctrl, 0);
        check("midrst_in_ready", in_ready, 0);
`ifdef DECODE_PERF_EN
        check("midrst_perf_groups", perf_groups, 0);
        check("midrst_perf_stalls", perf_stalls, 0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(2'b11, I_ILL, I_ADDI, C_ILL, C_I);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
